psx_pad_emulator: RTL and testbench



---
 rtl/psx_pkg.sv | 21 ++
 rtl/psx_pad_reply_table.sv | 37 +++
 rtl/psx_pad_emulator.sv | 121 ++++++++++++
 tb/tb_psx_pad_emulator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/psx_pkg.sv
// Shared constants and types for the PSX pad emulator.
// Imported by the reply table and the protocol stage.
package psx_pkg;

  localparam logic [7:0] PSX_CMD_POLL    = 8'h42;
  localparam logic [7:0] PSX_REPLY_IDLE  = 8'hFF;
  localparam logic [7:0] PSX_REPLY_READY = 8'h5A;

  localparam int         PSX_IDX_W   = 4;
  localparam logic [3:0] PSX_LEN_DIG = 4'd5;
  localparam logic [3:0] PSX_LEN_ANA = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_DATA,
    ST_DONE,
    ST_IGNORE
  } psx_state_e;

endpackage

// File: rtl/psx_pad_reply_table.sv
// Combinational reply byte lookup from reply index and snapshot.
// Bytes past the packet length read as idle.
module psx_pad_reply_table
  import psx_pkg::*;
#(
  parameter logic [7:0] ID_DIGITAL = 8'h41,
  parameter logic [7:0] ID_ANALOG  = 8'h73
) (
  input  logic [PSX_IDX_W-1:0] i_idx,
  input  logic [15:0]          i_buttons,
  input  logic [31:0]          i_sticks,
  input  logic                 i_analog,
  output logic [7:0]           o_reply
);

  logic [3:0] w_len;

  assign w_len = i_analog ? PSX_LEN_ANA : PSX_LEN_DIG;

  always_comb begin
    o_reply = PSX_REPLY_IDLE;
    if (i_idx < w_len) begin
      case (i_idx)
        4'd1:    o_reply = i_analog ? ID_ANALOG : ID_DIGITAL;
        4'd2:    o_reply = PSX_REPLY_READY;
        4'd3:    o_reply = i_buttons[7:0];
        4'd4:    o_reply = i_buttons[15:8];
        4'd5:    o_reply = i_sticks[7:0];
        4'd6:    o_reply = i_sticks[15:8];
        4'd7:    o_reply = i_sticks[23:16];
        4'd8:    o_reply = i_sticks[31:24];
        default: o_reply = PSX_REPLY_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/psx_pad_emulator.sv
// Dual Shock style pad protocol stage on the PPB.
// Answers poll packets from a per-packet controller snapshot.
module psx_pad_emulator
  import psx_pkg::*;
#(
  parameter logic [7:0] PAD_ADDRESS = 8'h01,
  parameter logic [7:0] ID_DIGITAL  = 8'h41,
  parameter logic [7:0] ID_ANALOG   = 8'h73
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PPB_packet_reset,
  input  logic [7:0]  PPB_command,
  input  logic        PPB_command_strobe,
  input  logic        PPB_reply_ready,
  output logic [7:0]  PPB_reply,
  output logic        PPB_ack_strobe,
  input  logic [15:0] pad_buttons,
  input  logic [31:0] pad_sticks,
  input  logic        pad_analog,
  output logic        poll_strobe
);

  logic                 w_rst;
  logic [3:0]           w_len;
  logic                 w_last;
  logic [7:0]           w_tbl;
  logic [15:0]          r_btn;
  logic [31:0]          r_stk;
  logic                 r_ana;
  psx_state_e           r_state;
  logic [PSX_IDX_W-1:0] r_cmd_idx;
  logic [PSX_IDX_W-1:0] r_rep_idx;
  logic [7:0]           r_reply;
  logic                 r_ack;
  logic                 r_poll;

  assign w_rst  = reset | PPB_packet_reset;
  assign w_len  = r_ana ? PSX_LEN_ANA : PSX_LEN_DIG;
  assign w_last = r_cmd_idx >= (w_len - 4'd1);

  assign PPB_reply      = r_reply;
  assign PPB_ack_strobe = r_ack;
  assign poll_strobe    = r_poll;

  psx_pad_reply_table #(
    .ID_DIGITAL (ID_DIGITAL),
    .ID_ANALOG  (ID_ANALOG)
  ) u_table (
    .i_idx     (r_rep_idx),
    .i_buttons (r_btn),
    .i_sticks  (r_stk),
    .i_analog  (r_ana),
    .o_reply   (w_tbl)
  );

  // Snapshot tracks live inputs while deselected, frozen for the packet.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_btn <= pad_buttons;
      r_stk <= pad_sticks;
      r_ana <= pad_analog;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_rep_idx <= '0;
      r_reply   <= PSX_REPLY_IDLE;
    end else begin
      if (PPB_reply_ready && r_rep_idx != 4'd15)
        r_rep_idx <= r_rep_idx + 4'd1;
      r_reply <= w_tbl;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state   <= ST_IDLE;
      r_cmd_idx <= '0;
      r_ack     <= 1'b0;
      r_poll    <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_poll <= 1'b0;
      if (PPB_command_strobe) begin
        if (r_cmd_idx != 4'd15)
          r_cmd_idx <= r_cmd_idx + 4'd1;
        unique case (r_state)
          ST_IDLE: begin
            if (PPB_command == PAD_ADDRESS) begin
              r_state <= ST_POLL;
              r_ack   <= 1'b1;
            end else begin
              r_state <= ST_IGNORE;
            end
          end
          ST_POLL: begin
            if (PPB_command == PSX_CMD_POLL) begin
              r_state <= ST_DATA;
              r_ack   <= 1'b1;
            end else begin
              r_state <= ST_IGNORE;
            end
          end
          ST_DATA: begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_poll  <= 1'b1;
            end else begin
              r_ack <= 1'b1;
            end
          end
          ST_DONE:   r_state <= ST_DONE;
          ST_IGNORE: r_state <= ST_IGNORE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psx_pad_emulator.sv
// Directed bench for psx_pad_emulator.
// Drives on negedge, samples after the posedge.
module tb_psx_pad_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        PPB_packet_reset;
  logic [7:0]  PPB_command;
  logic        PPB_command_strobe;
  logic        PPB_reply_ready;
  logic [7:0]  PPB_reply;
  logic        PPB_ack_strobe;
  logic [15:0] pad_buttons;
  logic [31:0] pad_sticks;
  logic        pad_analog;
  logic        poll_strobe;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cmds  [16];
  logic [7:0] reps  [16];
  logic       acks  [16];
  logic       polls [16];
  int         rst_at = -1;
  int         chg_at = -1;
  logic [15:0] chg_val;

  always #5 clk = ~clk;

  psx_pad_emulator dut (
    .clk                (clk),
    .reset              (reset),
    .PPB_packet_reset   (PPB_packet_reset),
    .PPB_command        (PPB_command),
    .PPB_command_strobe (PPB_command_strobe),
    .PPB_reply_ready    (PPB_reply_ready),
    .PPB_reply          (PPB_reply),
    .PPB_ack_strobe     (PPB_ack_strobe),
    .pad_buttons        (pad_buttons),
    .pad_sticks         (pad_sticks),
    .pad_analog         (pad_analog),
    .poll_strobe        (poll_strobe)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic start_pkt();
    PPB_packet_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_reply", PPB_reply, 8'hFF);
    PPB_packet_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_pkt(input string nm, input int n, input bit rdy,
                         input int exp_na, input int exp_np);
    int na;
    int np;
    na = 0;
    np = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_rep%0d", nm, i), PPB_reply, reps[i]);
      if (i == chg_at) pad_buttons = chg_val;
      PPB_reply_ready = rdy;
      @(negedge clk);
      PPB_reply_ready    = 1'b0;
      PPB_command        = cmds[i];
      PPB_command_strobe = 1'b1;
      if (i == rst_at) PPB_packet_reset = 1'b1;
      @(negedge clk);
      PPB_command_strobe = 1'b0;
      chk($sformatf("%s_ack%0d", nm, i), PPB_ack_strobe, acks[i]);
      chk($sformatf("%s_poll%0d", nm, i), poll_strobe, polls[i]);
      na += int'(PPB_ack_strobe);
      np += int'(poll_strobe);
      if (i == rst_at) return;
      @(negedge clk);
      na += int'(PPB_ack_strobe);
      np += int'(poll_strobe);
    end
    chk({nm, "_nack"}, na, exp_na);
    chk({nm, "_npoll"}, np, exp_np);
  endtask

  task automatic set_dig(input logic [7:0] c1, input logic [7:0] lo,
                         input logic [7:0] hi);
    cmds  = '{default: 8'h00};
    reps  = '{default: 8'hFF};
    acks  = '{default: 1'b0};
    polls = '{default: 1'b0};
    cmds[0] = 8'h01; cmds[1] = c1;
    reps[1] = 8'h41; reps[2] = 8'h5A; reps[3] = lo; reps[4] = hi;
  endtask

  initial begin
    reset = 1'b1;
    PPB_packet_reset = 1'b0;
    PPB_command = 8'h00;
    PPB_command_strobe = 1'b0;
    PPB_reply_ready = 1'b0;
    pad_buttons = 16'hFFFE;
    pad_sticks = 32'h80808080;
    pad_analog = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_reply", PPB_reply, 8'hFF);
    chk("por_ack", PPB_ack_strobe, 1'b0);
    chk("por_poll", poll_strobe, 1'b0);
    reset = 1'b0;

    // digital poll
    set_dig(8'h42, 8'hFE, 8'hFF);
    acks[0] = 1; acks[1] = 1; acks[2] = 1; acks[3] = 1; polls[4] = 1;
    start_pkt();
    run_pkt("dig", 5, 1'b1, 4, 1);

    // analog poll
    pad_analog  = 1'b1;
    pad_buttons = 16'h7FBF;
    pad_sticks  = {8'h10, 8'h20, 8'h30, 8'h40};
    cmds  = '{default: 8'h00};
    cmds[0] = 8'h01; cmds[1] = 8'h42;
    reps  = '{8'hFF, 8'h73, 8'h5A, 8'hBF, 8'h7F, 8'h40, 8'h30, 8'h20,
              8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    acks  = '{default: 1'b0};
    polls = '{default: 1'b0};
    for (int i = 0; i < 8; i++) acks[i] = 1'b1;
    polls[8] = 1'b1;
    start_pkt();
    run_pkt("ana", 9, 1'b1, 8, 1);
    pad_analog = 1'b0;

    // wrong address: host port stops fetching replies without an ack
    pad_buttons = 16'hFFFE;
    set_dig(8'h42, 8'hFF, 8'hFF);
    cmds[0] = 8'h81;
    reps[1] = 8'hFF; reps[2] = 8'hFF;
    start_pkt();
    run_pkt("addr", 5, 1'b0, 0, 0);

    // non-poll command; reply path keeps running
    set_dig(8'h43, 8'hFE, 8'hFF);
    acks[0] = 1;
    start_pkt();
    run_pkt("np", 5, 1'b1, 1, 0);

    // reset lands on the byte-2 strobe, then fresh packet
    pad_buttons = 16'h1234;
    set_dig(8'h42, 8'h34, 8'h12);
    acks[0] = 1; acks[1] = 1;
    rst_at = 2;
    start_pkt();
    run_pkt("mid", 5, 1'b1, 0, 0);
    chk("mid_reply_rst", PPB_reply, 8'hFF);
    rst_at = -1;
    pad_buttons = 16'hA55A;
    set_dig(8'h42, 8'h5A, 8'hA5);
    acks[0] = 1; acks[1] = 1; acks[2] = 1; acks[3] = 1; polls[4] = 1;
    start_pkt();
    run_pkt("mid2", 5, 1'b1, 4, 1);

    // snapshot stability
    pad_buttons = 16'hFFFF;
    chg_at  = 2;
    chg_val = 16'h0000;
    set_dig(8'h42, 8'hFF, 8'hFF);
    acks[0] = 1; acks[1] = 1; acks[2] = 1; acks[3] = 1; polls[4] = 1;
    start_pkt();
    run_pkt("snap", 5, 1'b1, 4, 1);
    chg_at = -1;
    set_dig(8'h42, 8'h00, 8'h00);
    acks[0] = 1; acks[1] = 1; acks[2] = 1; acks[3] = 1; polls[4] = 1;
    start_pkt();
    run_pkt("snap2", 5, 1'b1, 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
